// File: rtl/mxu_driver.sv
`default_nettype none
// ============================================================================
//  Module      : mxu_driver
//  Description : Upstream sequencer for the matrix multiply unit. Loads A/B
//                operand bytes into the MXU cache, writes the cycle count and
//                the start flag, polls status until done, then reads back
//                SIZE*SIZE accumulator results onto a valid/ready stream.
//                Optional build macro MXU_DRV_TIMEOUT_EN adds a poll timeout
//                that raises err and abandons the job.
//  Revision    : 1.0 - initial release
// ============================================================================
module mxu_driver #(
    parameter int          SIZE    = 4,
    parameter int          CYCLES  = 10,
    parameter int          RD_LAT  = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] awaddr,
    output logic [8:0]  wdata,
    output logic        wready,
    output logic [31:0] araddr,
    output logic        arready,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        done_pulse,
    output logic        err
);

    localparam int c_NN = SIZE * SIZE;
    localparam int c_IW = $clog2(2 * c_NN);
    localparam int c_KW = $clog2(c_NN + 1);
    localparam int c_WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [c_IW-1:0] c_IDX_LAST  = c_IW'(2 * c_NN - 1);
    localparam logic [c_KW-1:0] c_K_LAST    = c_KW'(c_NN);
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_LOAD      = 4'd0,
        S_CFG       = 4'd1,
        S_START     = 4'd2,
        S_POLL_REQ  = 4'd3,
        S_POLL_WAIT = 4'd4,
        S_RD_REQ    = 4'd5,
        S_RD_WAIT   = 4'd6,
        S_EMIT      = 4'd7,
        S_FIN       = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [c_IW-1:0] idx_q, idx_d;
    logic [c_KW-1:0] k_q, k_d;
    logic [c_WW-1:0] wait_q, wait_d;
    logic            in_ready_q, in_ready_d;
    logic            wready_q, wready_d;
    logic [31:0]     awaddr_q, awaddr_d;
    logic [8:0]      wdata_q, wdata_d;
    logic            arready_q, arready_d;
    logic [31:0]     araddr_q, araddr_d;
    logic [31:0]     res_data_q, res_data_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;
    logic            done_pulse_q, done_pulse_d;
`ifdef MXU_DRV_TIMEOUT_EN
    logic [15:0]     pcnt_q, pcnt_d;
    logic            err_q, err_d;
`else
    logic [31:0]     w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
`endif

    // Next-state and next-output computation; strobes default low every cycle
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        k_d          = k_q;
        wait_d       = wait_q;
        in_ready_d   = in_ready_q;
        wready_d     = 1'b0;
        awaddr_d     = 32'd0;
        wdata_d      = 9'd0;
        arready_d    = 1'b0;
        araddr_d     = 32'd0;
        res_data_d   = res_data_q;
        res_valid_d  = res_valid_q;
        done_pulse_d = 1'b0;
`ifdef MXU_DRV_TIMEOUT_EN
        pcnt_d       = pcnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    wready_d = 1'b1;
                    awaddr_d = 32'd2 + 32'(idx_q);
                    wdata_d  = {1'b0, in_data};
                    if (idx_q == c_IDX_LAST) begin
                        in_ready_d = 1'b0;
                        state_d    = S_CFG;
                    end else begin
                        idx_d = idx_q + c_IW'(1);
                    end
                end
            end
            S_CFG: begin
                wready_d = 1'b1;
                awaddr_d = 32'd1;
                wdata_d  = 9'(CYCLES);
                state_d  = S_START;
            end
            S_START: begin
                wready_d = 1'b1;
                awaddr_d = 32'd0;
                wdata_d  = 9'h001;
                state_d  = S_POLL_REQ;
`ifdef MXU_DRV_TIMEOUT_EN
                pcnt_d   = 16'd0;
`endif
            end
            S_POLL_REQ: begin
                arready_d = 1'b1;
                araddr_d  = 32'd0;
                wait_d    = '0;
                state_d   = S_POLL_WAIT;
`ifdef MXU_DRV_TIMEOUT_EN
                pcnt_d    = pcnt_q + 16'd1;
`endif
            end
            S_POLL_WAIT: begin
                if (wait_q == c_WAIT_LAST) begin
                    if (rdata[1]) begin
                        k_d     = c_KW'(1);
                        state_d = S_RD_REQ;
`ifdef MXU_DRV_TIMEOUT_EN
                    end else if ({16'd0, pcnt_q} > TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
`endif
                    end else begin
                        state_d = S_POLL_REQ;
                    end
                end else begin
                    wait_d = wait_q + c_WW'(1);
                end
            end
            S_RD_REQ: begin
                arready_d = 1'b1;
                araddr_d  = 32'(k_q);
                wait_d    = '0;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == c_WAIT_LAST) begin
                    res_data_d  = rdata;
                    res_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    wait_d = wait_q + c_WW'(1);
                end
            end
            S_EMIT: begin
                // Next read is only issued once the current result is taken
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (k_q == c_K_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        k_d     = k_q + c_KW'(1);
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_FIN: begin
                done_pulse_d = 1'b1;
                idx_d        = '0;
                k_d          = '0;
                in_ready_d   = 1'b1;
                state_d      = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        busy_d = (state_d != S_LOAD);
    end

    // State and registered outputs; reset lands in LOAD ready for operands
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            idx_q        <= '0;
            k_q          <= '0;
            wait_q       <= '0;
            in_ready_q   <= 1'b1;
            wready_q     <= 1'b0;
            awaddr_q     <= 32'd0;
            wdata_q      <= 9'd0;
            arready_q    <= 1'b0;
            araddr_q     <= 32'd0;
            res_data_q   <= 32'd0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b0;
`ifdef MXU_DRV_TIMEOUT_EN
            pcnt_q       <= 16'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            k_q          <= k_d;
            wait_q       <= wait_d;
            in_ready_q   <= in_ready_d;
            wready_q     <= wready_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            arready_q    <= arready_d;
            araddr_q     <= araddr_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            done_pulse_q <= done_pulse_d;
`ifdef MXU_DRV_TIMEOUT_EN
            pcnt_q       <= pcnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign wready     = wready_q;
    assign awaddr     = awaddr_q;
    assign wdata      = wdata_q;
    assign arready    = arready_q;
    assign araddr     = araddr_q;
    assign res_data   = res_data_q;
    assign res_valid  = res_valid_q;
    assign busy       = busy_q;
    assign done_pulse = done_pulse_q;
`ifdef MXU_DRV_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mxu_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mxu_driver
//  Description : Directed self-checking bench for mxu_driver with a small
//                behavioural MXU cache model (RD_LAT = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mxu_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] awaddr;
    logic [8:0]  wdata;
    logic        wready;
    logic [31:0] araddr;
    logic        arready;
    logic [31:0] rdata;
    logic        busy;
    logic        done_pulse;
    logic        err;

    always #5 clk = ~clk;

    mxu_driver #(.SIZE(4), .CYCLES(10), .RD_LAT(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .awaddr(awaddr), .wdata(wdata), .wready(wready),
        .araddr(araddr), .arready(arready), .rdata(rdata), .busy(busy),
        .done_pulse(done_pulse), .err(err)
    );

    // ---------------- MXU cache model ----------------
    logic [8:0] mem [64];
    int cyc = 0;
    int polls_since_start = 0;
    int done_after = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int rd_addr_q[$];

    function automatic logic [31:0] mxu_result(input int idx);
        int r;
        int c;
        logic [31:0] s;
        r = idx / 4;
        c = idx % 4;
        s = 32'd0;
        for (int t = 0; t < 4; t++)
            s = s + 32'(mem[2 + r*4 + t][7:0]) * 32'(mem[18 + t*4 + c][7:0]);
        return s;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wready) begin
            mem[awaddr[5:0]] <= wdata;
            wr_addr_q.push_back(int'(awaddr));
            wr_data_q.push_back(int'(wdata));
            wr_cyc_q.push_back(cyc);
            if (awaddr == 32'd0) polls_since_start <= 0;
        end
        if (arready) begin
            rd_addr_q.push_back(int'(araddr));
            if (araddr == 32'd0) begin
                rdata <= (polls_since_start >= done_after) ? 32'd2 : 32'd0;
                polls_since_start <= polls_since_start + 1;
            end else begin
                rdata <= mxu_result(int'(araddr) - 1);
            end
        end
    end

    // ---------------- bench state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  ops [32];
    logic [31:0] got [16];
    int ngot;
    int ndone;
    bit tmo;
    bit stall_ok;

    // A = scale*I (or all ones when scale==0), B = 1..16 row-major
    task automatic set_ops(input int scale);
        for (int i = 0; i < 16; i++) begin
            if (scale == 0) ops[i] = 8'd1;
            else            ops[i] = ((i / 4) == (i % 4)) ? 8'(scale) : 8'd0;
            ops[16 + i] = 8'(i + 1);
        end
    endtask

    task automatic send_job(input bit gap);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = ops[i];
            if (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int stall_at, input int stall_len);
        logic [31:0] held;
        ngot = 0; ndone = 0; tmo = 1'b0; stall_ok = 1'b1;
        res_ready = 1'b1;
        for (int c = 0; c < 3000 && ndone == 0; c++) begin
            @(negedge clk);
            if (done_pulse === 1'b1) ndone++;
            if (res_valid === 1'b1) begin
                if (ngot + 1 == stall_at) begin
                    held = res_data;
                    res_ready = 1'b0;
                    for (int s = 0; s < stall_len; s++) begin
                        @(negedge clk);
                        if (res_valid !== 1'b1 || res_data !== held || arready !== 1'b0)
                            stall_ok = 1'b0;
                    end
                    res_ready = 1'b1;
                end
                if (ngot < 16) got[ngot] = res_data;
                ngot++;
            end
        end
        if (ndone == 0) tmo = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_pulse === 1'b1) ndone++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_vec++;
        if ({wready, arready, res_valid, busy, done_pulse, err} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got=%b exp=000000",
                              {wready, arready, res_valid, busy, done_pulse, err});
        end
        n_vec++;
        if (awaddr !== 32'd0 || araddr !== 32'd0 || wdata !== 9'd0 || res_data !== 32'd0) begin
            n_err++; $display("FAIL reset_buses got aw=%0h ar=%0h wd=%0h rd=%0h exp=0",
                              awaddr, araddr, wdata, res_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int ws;
        ws = wr_addr_q.size();
        done_after = 2;
        set_ops(1);
        send_job(1'b0);
        collect(0, 0);
        n_vec++;
        if (tmo !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got=1 exp=0"); end
        n_vec++;
        if (wr_addr_q.size() - ws !== 34) begin
            n_err++; $display("FAIL b2b_write_count got=%0d exp=34", wr_addr_q.size() - ws);
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_vec++;
                if (wr_addr_q[ws+i] !== 2 + i || wr_data_q[ws+i] !== int'(ops[i])) begin
                    n_err++; $display("FAIL b2b_write%0d got a=%0d d=%0d exp a=%0d d=%0d", i,
                                      wr_addr_q[ws+i], wr_data_q[ws+i], 2 + i, ops[i]);
                end
            end
            n_vec++;
            if (wr_addr_q[ws+32] !== 1 || wr_data_q[ws+32] !== 10) begin
                n_err++; $display("FAIL b2b_cfg got a=%0d d=%0d exp a=1 d=10",
                                  wr_addr_q[ws+32], wr_data_q[ws+32]);
            end
            n_vec++;
            if (wr_addr_q[ws+33] !== 0 || wr_data_q[ws+33] !== 1) begin
                n_err++; $display("FAIL b2b_start got a=%0d d=%0d exp a=0 d=1",
                                  wr_addr_q[ws+33], wr_data_q[ws+33]);
            end
        end
        n_vec++;
        if (ngot !== 16) begin n_err++; $display("FAIL b2b_result_count got=%0d exp=16", ngot); end
        for (int i = 0; i < 16 && i < ngot; i++) begin
            n_vec++;
            if (got[i] !== 32'(i + 1)) begin
                n_err++; $display("FAIL b2b_result%0d got=%0d exp=%0d", i, got[i], i + 1);
            end
        end
        n_vec++;
        if (ndone !== 1) begin n_err++; $display("FAIL b2b_done_pulses got=%0d exp=1", ndone); end
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_idle got busy=%b in_ready=%b exp busy=0 in_ready=1",
                              busy, in_ready);
        end
    endtask

    task automatic test_gap;
        int ws;
        ws = wr_addr_q.size();
        done_after = 1;
        set_ops(0);
        send_job(1'b1);
        collect(0, 0);
        n_vec++;
        if (tmo !== 1'b0 || wr_addr_q.size() - ws !== 34) begin
            n_err++; $display("FAIL gap_job got tmo=%0d writes=%0d exp tmo=0 writes=34",
                              tmo, wr_addr_q.size() - ws);
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_vec++;
                if (wr_addr_q[ws+i] !== 2 + i) begin
                    n_err++; $display("FAIL gap_addr%0d got=%0d exp=%0d", i, wr_addr_q[ws+i], 2 + i);
                end
            end
            for (int i = 0; i < 31; i++) begin
                n_vec++;
                if (wr_cyc_q[ws+i+1] - wr_cyc_q[ws+i] !== 2) begin
                    n_err++; $display("FAIL gap_spacing%0d got=%0d exp=2", i,
                                      wr_cyc_q[ws+i+1] - wr_cyc_q[ws+i]);
                end
            end
        end
        // A all ones: each row is B's column sums 28,32,36,40
        for (int i = 0; i < 16 && i < ngot; i++) begin
            n_vec++;
            if (got[i] !== 32'(28 + 4 * (i % 4))) begin
                n_err++; $display("FAIL gap_result%0d got=%0d exp=%0d", i, got[i], 28 + 4 * (i % 4));
            end
        end
        n_vec++;
        if (ngot !== 16) begin n_err++; $display("FAIL gap_result_count got=%0d exp=16", ngot); end
    endtask

    task automatic test_stall;
        done_after = 0;
        set_ops(1);
        send_job(1'b0);
        collect(3, 20);
        n_vec++;
        if (stall_ok !== 1'b1) begin n_err++; $display("FAIL stall_hold got=0 exp=1"); end
        n_vec++;
        if (ngot !== 16 || tmo !== 1'b0) begin
            n_err++; $display("FAIL stall_count got=%0d tmo=%0d exp=16 tmo=0", ngot, tmo);
        end
        for (int i = 0; i < 16 && i < ngot; i++) begin
            n_vec++;
            if (got[i] !== 32'(i + 1)) begin
                n_err++; $display("FAIL stall_result%0d got=%0d exp=%0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_poll;
        int rs;
        int zeros;
        rs = rd_addr_q.size();
        done_after = 5;
        set_ops(1);
        send_job(1'b0);
        collect(0, 0);
        zeros = 0;
        while (rs + zeros < rd_addr_q.size() && rd_addr_q[rs + zeros] == 0) zeros++;
        n_vec++;
        if (zeros !== 6) begin n_err++; $display("FAIL poll_count got=%0d exp=6", zeros); end
        n_vec++;
        if (rs + zeros >= rd_addr_q.size() || rd_addr_q[rs + zeros] !== 1) begin
            n_err++; $display("FAIL poll_first_read got=%0d exp=1",
                              (rs + zeros < rd_addr_q.size()) ? rd_addr_q[rs + zeros] : -1);
        end
        n_vec++;
        if (rd_addr_q.size() - rs !== 22) begin
            n_err++; $display("FAIL poll_total_reads got=%0d exp=22", rd_addr_q.size() - rs);
        end
    endtask

    task automatic test_reset_mid;
        bit hit;
        int ws;
        done_after = 0;
        set_ops(1);
        res_ready = 1'b1;
        send_job(1'b0);
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk);
            if (arready === 1'b1 && araddr === 32'd7) hit = 1'b1;
        end
        n_vec++;
        if (!hit) begin n_err++; $display("FAIL mid_reach_rd7 got=0 exp=1"); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({wready, arready, res_valid, busy, done_pulse, err} !== 6'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_reset_flags got=%b in_ready=%b exp=000000 in_ready=1",
                              {wready, arready, res_valid, busy, done_pulse, err}, in_ready);
        end
        n_vec++;
        if (awaddr !== 32'd0 || araddr !== 32'd0 || wdata !== 9'd0 || res_data !== 32'd0) begin
            n_err++; $display("FAIL mid_reset_buses got aw=%0h ar=%0h wd=%0h rd=%0h exp=0",
                              awaddr, araddr, wdata, res_data);
        end
        reset = 1'b0;
        @(negedge clk);
        ws = wr_addr_q.size();
        set_ops(2);
        send_job(1'b0);
        collect(0, 0);
        n_vec++;
        if (ngot !== 16 || ndone !== 1 || wr_addr_q.size() - ws !== 34) begin
            n_err++; $display("FAIL mid_rerun got res=%0d done=%0d writes=%0d exp 16 1 34",
                              ngot, ndone, wr_addr_q.size() - ws);
        end
        for (int i = 0; i < 16 && i < ngot; i++) begin
            n_vec++;
            if (got[i] !== 32'(2 * (i + 1))) begin
                n_err++; $display("FAIL mid_result%0d got=%0d exp=%0d", i, got[i], 2 * (i + 1));
            end
        end
    endtask

`ifdef MXU_DRV_TIMEOUT_EN
    task automatic test_timeout;
        int rs;
        bit saw_valid;
        rs = rd_addr_q.size();
        done_after = 1000000;
        set_ops(1);
        send_job(1'b0);
        saw_valid = 1'b0;
        ndone = 0;
        for (int c = 0; c < 600 && ndone == 0; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) saw_valid = 1'b1;
            if (done_pulse === 1'b1) ndone++;
        end
        n_vec++;
        if (ndone !== 1) begin n_err++; $display("FAIL tmo_done got=%0d exp=1", ndone); end
        n_vec++;
        if (rd_addr_q.size() - rs !== 9) begin
            n_err++; $display("FAIL tmo_polls got=%0d exp=9", rd_addr_q.size() - rs);
        end
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL tmo_err got=%b exp=1", err); end
        n_vec++;
        if (saw_valid !== 1'b0) begin n_err++; $display("FAIL tmo_res_valid got=1 exp=0"); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL tmo_err_sticky got=%b exp=1", err); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL tmo_err_clear got=%b exp=0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_stall();
        test_poll();
        test_reset_mid();
`ifdef MXU_DRV_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
